// File: rtl/dp_pkg.sv
// Shared types and constants for the multicycle MIPS-style datapath.
// DP_MUL_EN (optional macro) enables the iterative multiplier on ALU code 1000.
package dp_pkg;

  localparam int unsigned DP_DATA_W = 32;
  localparam int unsigned DP_NREGS  = 32;

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    EXEC,
    MEM,
    WB
  } state_t;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_MUL = 4'b1000;
  localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port.
// Register 0 is hardwired to zero; the whole array clears on reset.
module dp_regfile
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W = DP_DATA_W,
  parameter int unsigned NREGS  = DP_NREGS,
  parameter int unsigned AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr_a,
  input  logic [AW-1:0]     i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = (i_raddr_a == '0) ? '0 : r_regs[i_raddr_a];
  assign o_rdata_b = (i_raddr_b == '0) ? '0 : r_regs[i_raddr_b];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath: IDLE -> DECODE -> EXEC -> (MEM) -> WB, one instruction in flight.
// Define DP_MUL_EN to enable the shift-add multiplier (ALU code 1000, DATA_W EXEC cycles).
module mc_datapath
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W = DP_DATA_W,
  parameter int unsigned NREGS  = DP_NREGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instruction,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              ALUScr,
  input  logic              RegWrite,
  input  logic              RegDst,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              MemtoReg,
  input  logic [3:0]        ALUControl,
  output logic              mem_req,
  output logic              mem_we,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ALUResult,
  output logic [DATA_W-1:0] w_scrB,
  output logic [DATA_W-1:0] out32,
  output logic              Zero,
  output logic              done,
  output logic              err
);

  localparam int unsigned AW = $clog2(NREGS);

  state_t            r_state;
  logic [31:0]       r_instr;
  logic              r_alusrc, r_regwrite, r_regdst;
  logic              r_memread, r_memwrite, r_memtoreg;
  logic [3:0]        r_op;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_ldata;

  logic [AW-1:0]     w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_rd_a, w_rd_b, w_sext, w_opb, w_alu_res, w_wdata;
  logic              w_alu_ok, w_lt, w_exec_done, w_we;
  logic              w_unused_instr;

  assign w_rs   = r_instr[21 +: AW];
  assign w_rt   = r_instr[16 +: AW];
  assign w_rd   = r_instr[11 +: AW];
  assign w_sext = {{(DATA_W-16){r_instr[15]}}, r_instr[15:0]};
  assign w_opb  = r_alusrc ? out32 : w_scrB;
  assign w_lt   = $signed(r_a) < $signed(w_opb);
  assign w_unused_instr = ^r_instr;

  assign in_ready = (r_state == IDLE);

`ifdef DP_MUL_EN
  localparam int unsigned CW = $clog2(DATA_W);
  logic [DATA_W-1:0] r_mcand, r_mplr, r_prod, w_prod_next;
  logic [CW-1:0]     r_cnt;

  assign w_prod_next = r_prod + (r_mplr[0] ? r_mcand : '0);
  assign w_exec_done = (r_op != ALU_MUL) || (r_cnt == CW'(DATA_W - 1));
`else
  assign w_exec_done = 1'b1;
`endif

  always_comb begin
    w_alu_ok  = 1'b1;
    w_alu_res = '0;
    case (r_op)
      ALU_AND: w_alu_res = r_a & w_opb;
      ALU_OR:  w_alu_res = r_a | w_opb;
      ALU_ADD: w_alu_res = r_a + w_opb;
      ALU_SUB: w_alu_res = r_a - w_opb;
      ALU_SLT: w_alu_res = DATA_W'(w_lt);
      ALU_NOR: w_alu_res = ~(r_a | w_opb);
`ifdef DP_MUL_EN
      ALU_MUL: w_alu_res = w_prod_next;
`endif
      default: w_alu_ok = 1'b0;
    endcase
  end

  assign w_we    = (r_state == WB) && r_regwrite && !err;
  assign w_wdata = r_memtoreg ? r_ldata : ALUResult;

  dp_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .AW     (AW)
  ) u_regfile (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_waddr   (r_regdst ? w_rd : w_rt),
    .i_wdata   (w_wdata),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_regdst   <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_op       <= '0;
      r_a        <= '0;
      r_ldata    <= '0;
      w_scrB     <= '0;
      out32      <= '0;
      ALUResult  <= '0;
      Zero       <= 1'b0;
      err        <= 1'b0;
      done       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
`ifdef DP_MUL_EN
      r_mcand    <= '0;
      r_mplr     <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_instr    <= instruction;
            r_alusrc   <= ALUScr;
            r_regwrite <= RegWrite;
            r_regdst   <= RegDst;
            r_memread  <= MemRead;
            r_memwrite <= MemWrite;
            r_memtoreg <= MemtoReg;
            r_op       <= ALUControl;
            err        <= 1'b0;
            r_state    <= DECODE;
          end
        end
        DECODE: begin
          r_a     <= w_rd_a;
          w_scrB  <= w_rd_b;
          out32   <= w_sext;
`ifdef DP_MUL_EN
          r_mcand <= w_rd_a;
          r_mplr  <= r_alusrc ? w_sext : w_rd_b;
          r_prod  <= '0;
          r_cnt   <= '0;
`endif
          r_state <= EXEC;
        end
        EXEC: begin
          if (!w_exec_done) begin
`ifdef DP_MUL_EN
            r_prod  <= w_prod_next;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CW'(1);
`endif
          end else begin
            ALUResult <= w_alu_res;
            Zero      <= (w_alu_res == '0);
            err       <= !w_alu_ok;
            // Illegal ops skip the memory phase so a bad store never reaches memory.
            if (w_alu_ok && (r_memread || r_memwrite)) begin
              mem_req <= 1'b1;
              mem_we  <= r_memwrite;
              r_state <= MEM;
            end else begin
              done    <= 1'b1;
              r_state <= WB;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (r_memread) r_ldata <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            done    <= 1'b1;
            r_state <= WB;
          end
        end
        WB: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_datapath.sv
// Self-checking bench for mc_datapath: directed cases plus randomized instructions
// checked against an arithmetic reference model of the register file and ALU.
module tb_mc_datapath;

  localparam int unsigned DW = 32;

  localparam logic [5:0] C_LOAD  = 6'b110101;
  localparam logic [5:0] C_STORE = 6'b100010;
  localparam logic [5:0] C_RTYPE = 6'b011000;
  localparam logic [5:0] C_ITYPE = 6'b110000;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   instruction;
  logic          in_valid, in_ready;
  logic          ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg;
  logic [3:0]    ALUControl;
  logic          mem_req, mem_we, mem_ack;
  logic [DW-1:0] mem_rdata, ALUResult, w_scrB, out32;
  logic          Zero, done, err;

  int unsigned   n_cmp = 0;
  int unsigned   n_err = 0;
  logic [31:0]   mreg [32];

  mc_datapath #(.DATA_W(DW), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .instruction(instruction), .in_valid(in_valid),
    .in_ready(in_ready), .ALUScr(ALUScr), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .ALUControl(ALUControl), .mem_req(mem_req), .mem_we(mem_we),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ALUResult(ALUResult),
    .w_scrB(w_scrB), .out32(out32), .Zero(Zero), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic model_alu(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic [31:0] r);
    longint unsigned prod;
    r = 32'd0;
    model_alu = 1'b1;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: r = a + b;
      4'b0110: r = a - b;
      4'b0111: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
`ifdef DP_MUL_EN
      4'b1000: begin prod = 64'(a) * 64'(b); r = prod[31:0]; end
`endif
      default: model_alu = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] mk_r(input int unsigned rs, input int unsigned rt,
                                       input int unsigned rd);
    mk_r = {6'd0, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] mk_i(input int unsigned rs, input int unsigned rt,
                                       input logic [15:0] imm);
    mk_i = {6'd0, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic scramble_inputs();
    logic [31:0] rnd;
    rnd = $urandom;
    instruction = $urandom;
    {ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg} = rnd[5:0];
    ALUControl = rnd[9:6];
  endtask

  task automatic do_instr(input string tag, input logic [31:0] ins, input logic [5:0] c,
                          input logic [3:0] op, input int unsigned waits,
                          input logic [31:0] rdata);
    logic [4:0]  rs, rt, rd, dst;
    logic [31:0] a, b, res;
    logic        legal, mem, seen;
    int unsigned lat, cyc, mcyc;
    rs = ins[25:21];
    rt = ins[20:16];
    rd = ins[15:11];
    a  = mreg[rs];
    b  = c[5] ? {{16{ins[15]}}, ins[15:0]} : mreg[rt];
    legal = model_alu(op, a, b, res);
    mem = legal && (c[2] || c[1]);
    lat = (legal && op == 4'b1000) ? DW + 2 : 3;
    if (mem) lat += waits;

    @(negedge clk);
    chk({tag, "/ready"}, in_ready, 1);
    instruction = ins;
    {ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg} = c;
    ALUControl = op;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    scramble_inputs();

    cyc = 0; mcyc = 0; seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      mem_ack = 1'b0;
      if (cyc == 1) chk({tag, "/busy"}, in_ready, 0);
      if (mem_req) begin
        mcyc++;
        if (mcyc == 1) begin
          chk({tag, "/addr"}, ALUResult, res);
          chk({tag, "/we"}, mem_we, c[1]);
          if (c[1]) chk({tag, "/sdata"}, w_scrB, mreg[rt]);
        end
        if (mcyc == waits) begin
          mem_ack = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_rdata = $urandom;
        end
      end
      if (done) seen = 1'b1;
    end
    mem_ack = 1'b0;
    chk({tag, "/done"}, seen, 1);
    chk({tag, "/lat"}, cyc, lat);
    chk({tag, "/res"}, ALUResult, res);
    chk({tag, "/zero"}, Zero, res == 32'd0);
    chk({tag, "/err"}, err, !legal);
    chk({tag, "/mcyc"}, mcyc, mem ? waits : 0);

    dst = c[3] ? rd : rt;
    if (legal && c[4] && dst != 5'd0) mreg[dst] = c[0] ? rdata : res;
  endtask

  task automatic ld(input int unsigned r, input logic [31:0] v, input int unsigned waits);
    do_instr("ld", mk_i(0, r, 16'h0000), C_LOAD, 4'b0010, waits, v);
  endtask

  initial begin
    logic [31:0] rnd, ins;
    logic [31:0] tmp;
    logic [3:0]  op;
    logic [5:0]  c;
    logic        ok;
    int unsigned k, w;
    logic [3:0]  ops [9];

    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110;
    ops[4] = 4'b0111; ops[5] = 4'b1100; ops[6] = 4'b1000; ops[7] = 4'b1010;
    ops[8] = 4'b1111;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    scramble_inputs();

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst/mem_req", mem_req, 0);
    chk("rst/done", done, 0);
    chk("rst/res", ALUResult, 0);
    chk("rst/out32", out32, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("rst/ready", in_ready, 1);

    // ADD r1+r2 -> r3
    ld(1, 32'd5, 1);
    ld(2, 32'd7, 2);
    do_instr("add", mk_r(1, 2, 3), C_RTYPE, 4'b0010, 0, 0);
    do_instr("rd_r3", mk_r(3, 0, 4), C_RTYPE, 4'b0001, 0, 0);
    // SUB equal, SLT signed
    ld(1, 32'd9, 1);
    ld(2, 32'd9, 1);
    do_instr("sub_eq", mk_r(1, 2, 5), C_RTYPE, 4'b0110, 0, 0);
    ld(1, 32'hFFFF_FFFF, 1);
    ld(2, 32'd1, 3);
    do_instr("slt", mk_r(1, 2, 6), C_RTYPE, 4'b0111, 0, 0);
    // load with negative offset and 4-cycle memory wait
    ld(1, 32'h10, 1);
    do_instr("ld_neg", mk_i(1, 7, 16'hFFFC), C_LOAD, 4'b0010, 4, 32'hABCD);
    do_instr("rd_r7", mk_r(7, 0, 8), C_RTYPE, 4'b0001, 0, 0);
    // register 0 ignores writes
    ld(0, 32'hFF, 1);
    do_instr("rd_r0", mk_r(0, 0, 8), C_RTYPE, 4'b0001, 0, 0);
    // illegal op leaves destination intact
    do_instr("illegal", mk_r(1, 2, 3), C_RTYPE, 4'b1010, 0, 0);
    do_instr("rd_r3b", mk_r(3, 0, 9), C_RTYPE, 4'b0001, 0, 0);
    // MUL (legal only with DP_MUL_EN)
    ld(1, 32'd6, 1);
    ld(2, 32'd7, 1);
    do_instr("mul", mk_r(1, 2, 9), C_RTYPE, 4'b1000, 0, 0);
    do_instr("rd_r9", mk_r(9, 0, 10), C_RTYPE, 4'b0001, 0, 0);
    do_instr("store", mk_i(1, 2, 16'h0004), C_STORE, 4'b0010, 2, 0);

    // reset during memory wait
    @(negedge clk);
    instruction = mk_i(1, 5, 16'h0004);
    {ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg} = C_LOAD;
    ALUControl = 4'b0010;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    k = 0;
    while (!mem_req && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rstmem/req_seen", mem_req, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rstmem/mem_req", mem_req, 0);
    chk("rstmem/res", ALUResult, 0);
    chk("rstmem/scrB", w_scrB, 0);
    chk("rstmem/out32", out32, 0);
    chk("rstmem/zero", Zero, 0);
    chk("rstmem/done", done, 0);
    chk("rstmem/err", err, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 32; i++) mreg[i] = 32'd0;
    #1 chk("rstmem/ready", in_ready, 1);
    ld(1, 32'd3, 2);
    do_instr("post_rst", mk_r(1, 2, 3), C_RTYPE, 4'b0010, 0, 0);

    // randomized instruction mix
    for (int i = 0; i < 40; i++) begin
      rnd = $urandom;
      op  = ops[rnd[3:0] % 9];
      ok  = model_alu(op, 32'd0, 32'd0, tmp);
      ins = $urandom;
      ins[25:21] = 5'(rnd[6:4]);
      ins[20:16] = 5'(rnd[9:7]);
      ins[15:11] = 5'(rnd[12:10]);
      case (ok ? rnd[14:13] : 2'd2)
        2'd0:    c = C_LOAD;
        2'd1:    c = C_STORE;
        2'd2:    c = C_RTYPE;
        default: c = C_ITYPE;
      endcase
      w = $urandom_range(1, 4);
      do_instr("rand", ins, c, op, w, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mc_datapath.md
MC_DATAPATH -- requirements
Module: mc_datapath

Interface
REQ-001 Parameter DATA_W, default 32: datapath width; legal 16..64.
REQ-002 Parameter NREGS, default 32: register count; power of 2, 2..32; register fields use low log2(NREGS) bits.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 instruction  in  32  MIPS-format word: rs[25:21], rt[20:16], rd[15:11], imm[15:0].
REQ-006 in_valid  in  1  instruction and control inputs valid; in_ready  out  1  high only in IDLE.
REQ-007 ALUScr, RegWrite, RegDst, MemRead, MemWrite, MemtoReg  in  1 each  control, sampled at accept.
REQ-008 ALUControl  in  4  ALU op, sampled at accept.
REQ-009 mem_req  out  1; mem_we  out  1; mem_ack  in  1; mem_rdata  in  DATA_W  memory handshake.
REQ-010 ALUResult  out  DATA_W  registered ALU result; also memory address.
REQ-011 w_scrB  out  DATA_W  latched rt value; store data.
REQ-012 out32  out  DATA_W  latched sign-extended immediate.
REQ-013 Zero  out  1  registered ALUResult==0; done  out  1  one-cycle completion pulse; err  out  1  illegal-op flag, valid with done.

Function
REQ-014 FSM states IDLE, DECODE, EXEC, MEM, WB, in dp_pkg state_t.
REQ-015 IDLE: in_valid && in_ready at edge latches instruction and controls -> DECODE; otherwise stay.
REQ-016 DECODE (1 cycle): latch A=reg[rs], B=reg[rt], out32=sign-extended imm -> EXEC.
REQ-017 EXEC: ALU operands A and (ALUScr ? out32 : B); ALUResult and Zero register at exit; -> MEM if MemRead|MemWrite, else WB.
REQ-018 ALU codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1/0), 1100 NOR; ADD/SUB wrap modulo 2^DATA_W.
REQ-019 Any other code (and 1000 when DP_MUL_EN undefined): ALUResult=0, Zero=1, err=1 with done; no register write.
REQ-020 MEM: mem_req=1, mem_we=MemWrite, held until mem_ack; on mem_ack latch mem_rdata if MemRead -> WB; no timeout.
REQ-021 WB (1 cycle): if RegWrite and not err, write reg[RegDst ? rd : rt] = MemtoReg ? loaded data : ALUResult; done=1; -> IDLE.
REQ-022 Writes to register 0 ignored; register 0 always reads 0.
REQ-023 Latency without memory: accept edge at cycle 0, done high in cycle 3; with memory, 3 + cycles until mem_ack inclusive.
REQ-024 Instruction written in WB is visible to the next DECODE (no hazard; one instruction in flight).
REQ-025 in_valid outside IDLE ignored; inputs need not be held after accept.

Reset
REQ-026 rst asserted at any time, including mid-operation or during MEM wait: state=IDLE, all registers and outputs 0, in_ready=1 after release, mem_req dropped immediately.

Configuration
REQ-027 Macro DP_MUL_EN defined: ALUControl 1000 = MUL, low DATA_W bits of unsigned product, iterative shift-add, EXEC occupies DATA_W cycles; undefined: 1000 illegal per REQ-019, no multiplier logic.

Structure
REQ-028 Package dp_pkg holds state_t, ALU op constants, default DATA_W/NREGS constants.
REQ-029 Register file is sub-module dp_regfile: 2 async read ports, 1 sync write port, async reset to 0.

Verification
REQ-030 ADD: reg1=5, reg2=7, ALUControl=0010, RegDst=1, rd=3 -> done at cycle 3, reg3=12, Zero=0.
REQ-031 SUB equal: reg1=reg2=9, 0110 -> ALUResult=0, Zero=1; SLT reg1=-1, reg2=1 -> 1.
REQ-032 Load: ALUScr=1, imm=0xFFFC, reg1=0x10 -> address 0x0C, mem_ack after 4 waits, mem_rdata=0xABCD written to rt, done at cycle 7.
REQ-033 Write to rd=0 with 0xFF -> reg0 reads 0; code 1010 -> err=1, no write.
REQ-034 rst pulsed during MEM wait -> mem_req=0 same cycle, outputs 0, in_ready=1, next instruction completes normally.
REQ-035 DP_MUL_EN: 6*7 -> 42 after DATA_W EXEC cycles; without macro -> err=1, result 0.
